// File: rtl/obstacle_fall_control.sv
// obstacle_fall_control
// Drops one object at a time toward the player box. It checks each falling
// object against the live box position and keeps the score and lives.
// All outputs are registered and change only on game ticks. The two
// exceptions are the LFSR, which runs every clk, and the one-clk event
// pulses, which clear on the next clk.
module obstacle_fall_control #(
  parameter logic [9:0] BOX_WIDTH   = 10'd30,
  parameter logic [9:0] BOX_Y       = 10'd440,
  parameter logic [9:0] BOX_HEIGHT  = 10'd20,
  parameter logic [9:0] OBJ_SIZE    = 10'd16,
  parameter logic [9:0] FALL_STEP   = 10'd4,
  parameter logic [7:0] SPAWN_DELAY = 8'd8,
  parameter logic [1:0] START_LIVES = 2'd3,
  parameter logic [9:0] LFSR_SEED   = 10'h155
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_en,
  input  logic [9:0] box_x,
  input  logic       restart,
  output logic [9:0] obj_x,
  output logic [9:0] obj_y,
  output logic       obj_active,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       hit_pulse,
  output logic       miss_pulse
);

  typedef enum logic [1:0] {
    ST_WAIT      = 2'd0,
    ST_FALLING   = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_t;

  localparam logic [10:0] SCREEN_H = 11'd480;
  localparam logic [9:0]  SPAWN_X_MAX = 10'd640 - OBJ_SIZE;

  state_t      state_r, state_nxt_s;
  logic [7:0]  wait_cnt_r, wait_cnt_nxt_s;
  logic [9:0]  lfsr_r;
  logic [9:0]  spawn_x_s;
  logic        overlap_s;
  logic        floor_s;
  logic        spawn_now_s;

  logic [9:0]  obj_x_nxt_s, obj_y_nxt_s;
  logic        obj_active_nxt_s;
  logic [7:0]  score_nxt_s;
  logic [1:0]  lives_nxt_s;
  logic        game_over_nxt_s;
  logic        hit_nxt_s, miss_nxt_s;

  // Rectangle intersection test in 11 bits so that the sums cannot wrap.
  function automatic logic rect_overlap(input logic [9:0] ox, input logic [9:0] oy,
                                        input logic [9:0] bx);
    logic [10:0] ox_w, oy_w, bx_w;
    ox_w = {1'b0, ox};
    oy_w = {1'b0, oy};
    bx_w = {1'b0, bx};
    rect_overlap = ((oy_w + {1'b0, OBJ_SIZE}) > {1'b0, BOX_Y}) &&
                   (oy_w < ({1'b0, BOX_Y} + {1'b0, BOX_HEIGHT})) &&
                   ((ox_w + {1'b0, OBJ_SIZE}) > bx_w) &&
                   (ox_w < (bx_w + {1'b0, BOX_WIDTH}));
  endfunction

  assign overlap_s   = rect_overlap(obj_x, obj_y, box_x);
  assign floor_s     = (({1'b0, obj_y} + {1'b0, OBJ_SIZE} + {1'b0, FALL_STEP}) > SCREEN_H);
  assign spawn_now_s = (wait_cnt_r == (SPAWN_DELAY - 8'd1));
  // Values above the last legal column fold down by 512 and land in 0..511.
  assign spawn_x_s   = (lfsr_r <= SPAWN_X_MAX) ? lfsr_r : (lfsr_r - 10'd512);

  // LFSR free-runs every clk (x^10 + x^7 + 1) so spawn columns differ between rounds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {lfsr_r[8:0], lfsr_r[9] ^ lfsr_r[6]};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_WAIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic, advancing only on game ticks.
  always_comb begin
    state_nxt_s = state_r;
    if (game_en) begin
      case (state_r)
        ST_WAIT: begin
          if (spawn_now_s) state_nxt_s = ST_FALLING;
          else             state_nxt_s = ST_WAIT;
        end
        ST_FALLING: begin
          if (overlap_s)                state_nxt_s = ST_WAIT;
          else if (floor_s && (lives == 2'd1)) state_nxt_s = ST_GAME_OVER;
          else if (floor_s)             state_nxt_s = ST_WAIT;
          else                          state_nxt_s = ST_FALLING;
        end
        ST_GAME_OVER: begin
          if (restart) state_nxt_s = ST_WAIT;
          else         state_nxt_s = ST_GAME_OVER;
        end
        default: state_nxt_s = ST_WAIT;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Next values of the datapath and output registers for the current tick.
  always_comb begin
    wait_cnt_nxt_s   = wait_cnt_r;
    obj_x_nxt_s      = obj_x;
    obj_y_nxt_s      = obj_y;
    obj_active_nxt_s = obj_active;
    score_nxt_s      = score;
    lives_nxt_s      = lives;
    game_over_nxt_s  = game_over;
    hit_nxt_s        = 1'b0;
    miss_nxt_s       = 1'b0;
    if (game_en) begin
      case (state_r)
        ST_WAIT: begin
          if (spawn_now_s) begin
            obj_x_nxt_s      = spawn_x_s;
            obj_y_nxt_s      = 10'd0;
            obj_active_nxt_s = 1'b1;
            wait_cnt_nxt_s   = 8'd0;
          end else begin
            wait_cnt_nxt_s   = wait_cnt_r + 8'd1;
          end
        end
        ST_FALLING: begin
          if (overlap_s) begin
            // A catch wins over a floor miss on the same tick.
            hit_nxt_s        = 1'b1;
            obj_active_nxt_s = 1'b0;
            if (score != 8'd255) score_nxt_s = score + 8'd1;
            else                 score_nxt_s = score;
          end else if (floor_s) begin
            miss_nxt_s       = 1'b1;
            obj_active_nxt_s = 1'b0;
            lives_nxt_s      = lives - 2'd1;
            if (lives == 2'd1) game_over_nxt_s = 1'b1;
            else               game_over_nxt_s = game_over;
          end else begin
            obj_y_nxt_s      = obj_y + FALL_STEP;
          end
        end
        ST_GAME_OVER: begin
          if (restart) begin
            score_nxt_s      = 8'd0;
            lives_nxt_s      = START_LIVES;
            game_over_nxt_s  = 1'b0;
            wait_cnt_nxt_s   = 8'd0;
            obj_active_nxt_s = 1'b0;
          end else begin
            game_over_nxt_s  = 1'b1;
            obj_active_nxt_s = 1'b0;
            lives_nxt_s      = 2'd0;
          end
        end
        default: begin
          wait_cnt_nxt_s   = 8'd0;
          obj_active_nxt_s = 1'b0;
        end
      endcase
    end else begin
      wait_cnt_nxt_s = wait_cnt_r;
    end
  end

  // Datapath and output registers; the pulses clear on every clk without a new event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= 8'd0;
      obj_x      <= 10'd0;
      obj_y      <= 10'd0;
      obj_active <= 1'b0;
      score      <= 8'd0;
      lives      <= START_LIVES;
      game_over  <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      wait_cnt_r <= wait_cnt_nxt_s;
      obj_x      <= obj_x_nxt_s;
      obj_y      <= obj_y_nxt_s;
      obj_active <= obj_active_nxt_s;
      score      <= score_nxt_s;
      lives      <= lives_nxt_s;
      game_over  <= game_over_nxt_s;
      hit_pulse  <= hit_nxt_s;
      miss_pulse <= miss_nxt_s;
    end
  end

endmodule

// File: doc/obstacle_fall_control.md
# obstacle_fall_control

Drops one falling object at a time toward the player box, checks it against the player box position, and keeps score and lives. It sits directly downstream of the player movement block: it consumes the player's 10-bit `box_x` and the same slow `game_en` tick. It feeds the VGA renderer (object position/visibility) and the HUD/LED logic (score, lives, game over).

## Interface
Parameters:
- `BOX_WIDTH`, 10'd30: player box width in pixels. Must match the player movement block.
- `BOX_Y`, 10'd440: top row of the player box.
- `BOX_HEIGHT`, 10'd20: player box height.
- `OBJ_SIZE`, 10'd16: object edge length (square).
- `FALL_STEP`, 10'd4: pixels fallen per game tick.
- `SPAWN_DELAY`, 8'd8: game ticks spent in WAIT before each spawn. Legal range is 1..255.
- `START_LIVES`, 2'd3: lives loaded at reset and on restart.
- `LFSR_SEED`, 10'h155: nonzero LFSR reset value.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `game_en`, in, 1: one-clk game tick enable.
- `box_x`, in, 10: player box left x (0..639-BOX_WIDTH+1).
- `restart`, in, 1: active-high. Sampled only in GAME_OVER on a tick.
- `obj_x`, out, 10: object left x.
- `obj_y`, out, 10: object top y.
- `obj_active`, out, 1: object is visible/falling.
- `score`, out, 8: catches, saturating at 255.
- `lives`, out, 2: remaining lives.
- `game_over`, out, 1: high in GAME_OVER.
- `hit_pulse`, out, 1: one-clk pulse per catch.
- `miss_pulse`, out, 1: one-clk pulse per miss.

## Operation
- States: WAIT, FALLING, GAME_OVER. All state and outputs change only on clk edges where `game_en`=1. The exceptions are the LFSR and the pulse clears.
- Reset values:
  - state WAIT, wait_cnt 0, lfsr `LFSR_SEED`
  - `obj_x`=0, `obj_y`=0, `obj_active`=0
  - `score`=0, `lives`=`START_LIVES`
  - `game_over`=0, both pulses 0
- LFSR: 10-bit Fibonacci, taps x^10+x^7+1. It advances every clk regardless of `game_en`.
- spawn_x = lfsr if lfsr ≤ 640-OBJ_SIZE (624), else lfsr-512.
- WAIT, on each tick:
  - If wait_cnt == SPAWN_DELAY-1: go to FALLING, `obj_x`=spawn_x, `obj_y`=0, `obj_active`=1, wait_cnt=0.
  - Else wait_cnt+1.
- FALLING, on each tick, evaluated on the current registered `obj_y`/`obj_x` and the live `box_x`. Use 11-bit arithmetic for all sums; there is no wrap.
  - Overlap is true when all of these hold: `obj_y`+OBJ_SIZE > BOX_Y, `obj_y` < BOX_Y+BOX_HEIGHT, `obj_x`+OBJ_SIZE > `box_x`, `obj_x` < `box_x`+BOX_WIDTH.
  - If overlap: `score`+1 (hold at 255), `hit_pulse`, `obj_active`=0, go to WAIT.
  - Else if `obj_y`+OBJ_SIZE+FALL_STEP > 480: `miss_pulse`, `obj_active`=0, `lives`-1. If `lives` was 1, go to GAME_OVER; else go to WAIT.
  - Else `obj_y`+=FALL_STEP.
  - A hit has priority over a miss on the same tick.
- GAME_OVER: `game_over`=1, `obj_active`=0, `lives`=0, and `score` is held.
  - On a tick with `restart`=1: `score`=0, `lives`=`START_LIVES`, `game_over`=0, wait_cnt=0, go to WAIT.
- `obj_x`/`obj_y` hold their last values while `obj_active`=0.
- Reset asserted mid-fall or in GAME_OVER immediately forces the reset values. The LFSR returns to its seed.

## Timing
- All outputs are registered. Updates appear one clk after the `game_en` cycle that caused them.
- `hit_pulse` and `miss_pulse` are high for exactly one clk, in the cycle after the causing tick. They are cleared on the next clk whether or not `game_en` is high.
- Spawn latency: the object appears on the SPAWN_DELAY-th tick after entering WAIT.
- Defaults, counting ticks after spawn (spawn tick = 0, check on tick k uses y=4(k-1)):
  - A box under the object gives a hit on tick 108 (y=428).
  - An uncaught object misses on tick 117 (y=464).
- `restart` held high outside GAME_OVER is ignored.

## Test plan
- Reset, then 8 ticks → `obj_active`=1 after tick 8, `obj_y`=0, `obj_x`≤624. No tick occurs during the first 5 clks after reset → all outputs hold their reset values.
- Spawn, then hold `box_x`=`obj_x` → on tick 108 `hit_pulse` is high for 1 clk, `score`=1, `obj_active`=0. The next spawn comes 8 ticks later.
- Spawn, then `box_x` placed so `box_x`+30 = `obj_x` (edge-adjacent, no overlap) → no hit. On tick 117 `miss_pulse` fires, `lives`=2.
- Three consecutive misses → `lives`=0, `game_over`=1, `obj_active` stays 0. Further ticks with `restart`=0 change nothing.
- In GAME_OVER, `restart`=1 on a tick → `score`=0, `lives`=3, `game_over`=0, a spawn 8 ticks later. With `restart`=1 held during FALLING → no effect.
- Force `score`=255 by preloading or 255 catches, then one more catch → `score` stays 255 and `hit_pulse` still fires. Assert `rst` mid-fall → reset values on the next sample, independent of `clk`.
